// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the fetch sequencer's handshakes: run control, instruction-memory
// read and write ports, loader, redirect and the decode-facing fetch slot.
interface imem_fetch_ctrl_if;
  // Run control
  logic        start;
  logic        stop;
  // Instruction memory read port
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  // Loader and instruction memory write port
  logic        load_valid;
  logic        load_ready;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  // Branch/jump redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Fetch slot towards decode
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  // Status
  logic        halted;
  logic        err;

  // Environment side: drives control, loader, redirect and returns memory data
  modport master (
    output start, stop, imem_instruction, load_valid, load_addr, load_data,
           redirect_valid, redirect_pc, if_ready,
    input  imem_pc, load_ready, imem_we, imem_waddr, imem_wdata,
           if_valid, if_instr, if_pc, halted, err
  );

  // Sequencer side
  modport slave (
    input  start, stop, imem_instruction, load_valid, load_addr, load_data,
           redirect_valid, redirect_pc, if_ready,
    output imem_pc, load_ready, imem_we, imem_waddr, imem_wdata,
           if_valid, if_instr, if_pc, halted, err
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills a single valid/ready fetch
// slot from a combinational instruction memory, applies redirects, halts on
// the zero word that terminates the program image, and lets a loader write
// the memory while idle.
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH        = 64,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          STOP_ON_ZERO = 1'b1
) (
  input logic             clk,
  input logic             rst,
  imem_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        we_q, we_d;
  logic [5:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic slot_free;
  logic out_of_range;

  // Slot can take a new word when empty or when decode drains it this cycle.
  assign slot_free    = !if_valid_q || bus.if_ready;
  assign out_of_range = {2'b00, pc_q[31:2]} >= 32'(DEPTH);

  // Next-state and slot/write-port update; stop beats redirect beats capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        // A load coinciding with start is still written.
        we_d = bus.load_valid;
        if (bus.load_valid) begin
          waddr_d = bus.load_addr;
          wdata_d = bus.load_data;
        end
        if (bus.start) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end

      StRun: begin
        if (bus.stop) begin
          state_d    = StIdle;
          if_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          // Any capture this cycle is killed; the target is fetched next edge.
          if_valid_d = 1'b0;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = StHalt;
            err_d   = 1'b1;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (slot_free) begin
          if (out_of_range) begin
            state_d    = StHalt;
            err_d      = 1'b1;
            if_valid_d = 1'b0;
          end else if (STOP_ON_ZERO && (bus.imem_instruction == 32'h0)) begin
            // End-of-image marker is never presented to decode.
            state_d    = StHalt;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = bus.imem_instruction;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end

      StHalt: begin
        if_valid_d = 1'b0;
        if (bus.start) begin
          state_d = StRun;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      we_q       <= 1'b0;
      waddr_q    <= 6'd0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.imem_pc    = pc_q;
  assign bus.load_ready = (state_q == StIdle);
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_instr   = if_instr_q;
  assign bus.if_pc      = if_pc_q;
  assign bus.halted     = (state_q == StHalt);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural instruction memory and
// a scoreboard of expected {instr, pc} pairs consumed at each fetch handshake.
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if dut_if ();

  imem_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  // Behavioural 64-word memory: registered write, combinational read.
  logic [31:0] mem [64] = '{default: 32'h0};

  always @(posedge clk) begin
    if (dut_if.imem_we) mem[dut_if.imem_waddr] <= dut_if.imem_wdata;
  end

  assign dut_if.imem_instruction = (dut_if.imem_pc[31:8] == 24'h0) ?
                                   mem[dut_if.imem_pc[7:2]] : 32'h0;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0010_0113;
  localparam logic [31:0] W4 = 32'h0020_0193;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    sb.push_back({instr, pc});
  endtask

  // Handshake monitor: inputs are stable by the falling edge, so a handshake
  // seen here is the one the next rising edge commits.
  always @(negedge clk) begin
    if (!rst && dut_if.if_valid && dut_if.if_ready) begin
      logic [63:0] e;
      check("slot_nonzero", 32'(dut_if.if_instr != 32'h0), 32'd1);
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_instr", dut_if.if_instr, e[63:32]);
        check("sb_pc", dut_if.if_pc, e[31:0]);
      end
    end
  end

  initial begin
    logic [5:0]  la [4];
    logic [31:0] ld [4];
    la = '{6'd0, 6'd1, 6'd2, 6'd4};
    ld = '{W0, W1, 32'h0, W4};

    dut_if.start          = 1'b0;
    dut_if.stop           = 1'b0;
    dut_if.load_valid     = 1'b0;
    dut_if.load_addr      = 6'd0;
    dut_if.load_data      = 32'h0;
    dut_if.redirect_valid = 1'b0;
    dut_if.redirect_pc    = 32'h0;
    dut_if.if_ready       = 1'b0;

    step();
    step();
    rst = 1'b0;
    check("rst_load_ready", 32'(dut_if.load_ready), 32'd1);
    check("rst_if_valid", 32'(dut_if.if_valid), 32'd0);
    check("rst_halted", 32'(dut_if.halted), 32'd0);
    check("rst_err", 32'(dut_if.err), 32'd0);
    check("rst_imem_pc", dut_if.imem_pc, 32'h0);
    check("rst_imem_we", 32'(dut_if.imem_we), 32'd0);

    // Load program image.
    for (int i = 0; i < 4; i++) begin
      dut_if.load_valid = 1'b1;
      dut_if.load_addr  = la[i];
      dut_if.load_data  = ld[i];
      step();
      check("load_we", 32'(dut_if.imem_we), 32'd1);
      check("load_waddr", 32'(dut_if.imem_waddr), 32'(la[i]));
      check("load_wdata", dut_if.imem_wdata, ld[i]);
    end
    dut_if.load_valid = 1'b0;
    step();
    check("load_we_off", 32'(dut_if.imem_we), 32'd0);

    // Run to the zero word.
    push(W0, 32'h0);
    push(W1, 32'h4);
    dut_if.if_ready = 1'b1;
    dut_if.start    = 1'b1;
    step();
    dut_if.start = 1'b0;
    check("run_load_ready", 32'(dut_if.load_ready), 32'd0);
    check("run_first_invalid", 32'(dut_if.if_valid), 32'd0);
    step();
    check("run_first_valid", 32'(dut_if.if_valid), 32'd1);
    check("run_first_pc", dut_if.if_pc, 32'h0);
    repeat (4) step();
    check("run_halted", 32'(dut_if.halted), 32'd1);
    check("run_halt_if_valid", 32'(dut_if.if_valid), 32'd0);
    check("run_sb_drained", 32'(sb.size()), 32'd0);
    dut_if.load_valid = 1'b1;
    dut_if.load_addr  = 6'd9;
    step();
    dut_if.load_valid = 1'b0;
    check("halt_load_ignored", 32'(dut_if.imem_we), 32'd0);

    // Backpressure.
    dut_if.if_ready = 1'b0;
    push(W0, 32'h0);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(dut_if.if_valid), 32'd1);
      check("bp_instr", dut_if.if_instr, W0);
      check("bp_pc", dut_if.if_pc, 32'h0);
      check("bp_imem_pc", dut_if.imem_pc, 32'h4);
      if (i < 3) step();
    end
    push(W1, 32'h4);
    dut_if.if_ready = 1'b1;
    repeat (4) step();
    check("bp_halted", 32'(dut_if.halted), 32'd1);
    check("bp_sb_drained", 32'(sb.size()), 32'd0);

    // Redirect to 0x10 while pc 0x4 is being consumed.
    push(W0, 32'h0);
    push(W1, 32'h4);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    step();
    check("redir_src_valid", 32'(dut_if.if_valid), 32'd1);
    check("redir_src_pc", dut_if.if_pc, 32'h4);
    push(W4, 32'h10);
    dut_if.redirect_valid = 1'b1;
    dut_if.redirect_pc    = 32'h10;
    step();
    dut_if.redirect_valid = 1'b0;
    check("redir_bubble", 32'(dut_if.if_valid), 32'd0);
    check("redir_imem_pc", dut_if.imem_pc, 32'h10);
    step();
    check("redir_tgt_valid", 32'(dut_if.if_valid), 32'd1);
    check("redir_tgt_pc", dut_if.if_pc, 32'h10);
    check("redir_tgt_instr", dut_if.if_instr, W4);
    repeat (3) step();
    check("redir_halted", 32'(dut_if.halted), 32'd1);
    check("redir_err", 32'(dut_if.err), 32'd0);

    // Misaligned redirect, then restart clears err.
    push(W0, 32'h0);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    dut_if.redirect_valid = 1'b1;
    dut_if.redirect_pc    = 32'h12;
    step();
    dut_if.redirect_valid = 1'b0;
    check("mis_halted", 32'(dut_if.halted), 32'd1);
    check("mis_err", 32'(dut_if.err), 32'd1);
    check("mis_if_valid", 32'(dut_if.if_valid), 32'd0);
    push(W0, 32'h0);
    push(W1, 32'h4);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    check("mis_restart_err", 32'(dut_if.err), 32'd0);
    check("mis_restart_halted", 32'(dut_if.halted), 32'd0);
    repeat (5) step();
    check("mis_rerun_halted", 32'(dut_if.halted), 32'd1);
    check("mis_sb_drained", 32'(sb.size()), 32'd0);

    // Out-of-range redirect target.
    push(W0, 32'h0);
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    dut_if.redirect_valid = 1'b1;
    dut_if.redirect_pc    = 32'h100;
    step();
    dut_if.redirect_valid = 1'b0;
    check("oor_bubble", 32'(dut_if.if_valid), 32'd0);
    check("oor_imem_pc", dut_if.imem_pc, 32'h100);
    check("oor_not_yet_halted", 32'(dut_if.halted), 32'd0);
    step();
    check("oor_halted", 32'(dut_if.halted), 32'd1);
    check("oor_err", 32'(dut_if.err), 32'd1);
    check("oor_if_valid", 32'(dut_if.if_valid), 32'd0);
    check("oor_no_capture", dut_if.if_pc, 32'h0);

    // Reset in the middle of a run with a full slot and a pending load.
    dut_if.if_ready = 1'b0;
    dut_if.start    = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    check("mid_valid", 32'(dut_if.if_valid), 32'd1);
    rst               = 1'b1;
    dut_if.load_valid = 1'b1;
    dut_if.load_addr  = 6'd3;
    dut_if.load_data  = 32'hDEAD_BEEF;
    step();
    rst               = 1'b0;
    dut_if.load_valid = 1'b0;
    check("mrst_if_valid", 32'(dut_if.if_valid), 32'd0);
    check("mrst_if_instr", dut_if.if_instr, 32'h0);
    check("mrst_if_pc", dut_if.if_pc, 32'h0);
    check("mrst_imem_pc", dut_if.imem_pc, 32'h0);
    check("mrst_we", 32'(dut_if.imem_we), 32'd0);
    check("mrst_waddr", 32'(dut_if.imem_waddr), 32'd0);
    check("mrst_wdata", dut_if.imem_wdata, 32'h0);
    check("mrst_halted", 32'(dut_if.halted), 32'd0);
    check("mrst_err", 32'(dut_if.err), 32'd0);
    check("mrst_load_ready", 32'(dut_if.load_ready), 32'd1);

    // Simultaneous stop and redirect: stop wins.
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    step();
    dut_if.stop           = 1'b1;
    dut_if.redirect_valid = 1'b1;
    dut_if.redirect_pc    = 32'h10;
    step();
    dut_if.stop           = 1'b0;
    dut_if.redirect_valid = 1'b0;
    check("stop_load_ready", 32'(dut_if.load_ready), 32'd1);
    check("stop_if_valid", 32'(dut_if.if_valid), 32'd0);
    check("stop_halted", 32'(dut_if.halted), 32'd0);
    check("stop_pc_kept", dut_if.imem_pc, 32'h4);

    // Loader is locked out while running.
    dut_if.start = 1'b1;
    step();
    dut_if.start      = 1'b0;
    dut_if.load_valid = 1'b1;
    dut_if.load_addr  = 6'd7;
    dut_if.load_data  = 32'h1234_5678;
    step();
    check("run_load_we0", 32'(dut_if.imem_we), 32'd0);
    step();
    check("run_load_we1", 32'(dut_if.imem_we), 32'd0);
    dut_if.load_valid = 1'b0;
    dut_if.stop       = 1'b1;
    step();
    dut_if.stop = 1'b0;
    check("final_idle", 32'(dut_if.load_ready), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64-word combinational instruction memory.
- Owns the PC and drives the word-aligned read address.
- Registers the fetched word into a valid/ready slot for decode, and applies branch/jump redirects.
- Stops on an all-zero word, which marks the end of the zero-filled program image.
- In IDLE it also arbitrates the memory's write port so a program loader can fill the memory before a run.

Parameters:
- DEPTH, 64: instruction memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000: byte address of the first instruction after start.
- STOP_ON_ZERO, 1: when 1, fetching instruction 32'h0 halts the sequencer.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  pulse; IDLE/HALT -> RUN from RESET_PC
- stop  input  1  pulse; RUN -> IDLE, flushes the slot
- imem_pc  output  32  byte address to instruction memory, combinational = pc
- imem_instruction  input  32  word read at imem_pc, same cycle
- load_valid  input  1  loader write request
- load_ready  output  1  high only in IDLE
- load_addr  input  6  loader word index
- load_data  input  32  loader word
- imem_we  output  1  registered write enable to instruction memory
- imem_waddr  output  6  registered write word index
- imem_wdata  output  32  registered write data
- redirect_valid  input  1  branch/jump taken
- redirect_pc  input  32  target byte address
- if_valid  output  1  fetch slot holds an instruction
- if_ready  input  1  decode accepts slot
- if_instr  output  32  fetched instruction
- if_pc  output  32  byte address of if_instr
- halted  output  1  sequencer in HALT
- err  output  1  sticky: misaligned or out-of-range PC

Behaviour:
- Reset (rst high at edge), synchronous: state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, imem_we=0, imem_waddr=0, imem_wdata=0, halted=0, err=0. Reset overrides every other input in the same cycle, including mid-RUN and mid-load.
- States: IDLE, RUN, HALT.
- IDLE:
  - load_ready=1.
  - load_valid -> next cycle imem_we=1 with the captured load_addr/load_data; otherwise imem_we=0.
  - start -> RUN with pc=RESET_PC.
  - start together with load_valid: the load is written and the state still goes to RUN.
- RUN:
  - load_ready=0, imem_we=0.
  - Slot is free when if_valid=0 or (if_valid & if_ready).
  - When free: capture if_instr=imem_instruction, if_pc=pc, if_valid=1, pc=pc+4 (32-bit wrap).
  - When the slot is stalled, pc and the slot hold.
- End of program: a captured word of 32'h0 with STOP_ON_ZERO=1 is not presented; if_valid goes to 0 and the state goes to HALT.
- Out of range: pc>>2 >= DEPTH at a capture -> HALT, err=1, no capture.
- Redirect (in RUN only):
  - pc=redirect_pc and if_valid=0 at the next edge; any capture in that cycle is killed.
  - A handshake completing in that same cycle still counts as consumed.
  - The target word is captured on the following edge, so if_valid at the target appears 2 cycles after the redirect.
  - redirect_pc[1:0]!=0 -> HALT, err=1.
- stop in RUN -> IDLE, if_valid=0. Priority: stop > redirect > capture.
- HALT:
  - halted=1, if_valid=0, pc frozen.
  - start -> RUN with pc=RESET_PC and halted=0, err=0.
  - load_valid is ignored.
- Latency: start at edge t -> state RUN after t; first if_valid=1 after edge t+1 with if_pc=RESET_PC. Steady state is 1 instruction per cycle while if_ready=1.
- Redirect/start/stop/load inputs outside the states above are ignored.

Test Plan:
- Load, then run: load words 0x00500093, 0x00100113, 0x0 at indices 0..2, then start with if_ready=1 -> imem_we pulses one cycle after each load; if_instr 0x00500093@pc0, then 0x00100113@pc4; HALT; halted=1; if_valid never shows 0x0.
- Backpressure: hold if_ready=0 for 3 cycles after the first valid -> if_instr/if_pc stable at 0x00500093/0; imem_pc stays 4; resume gives pc4 next.
- Redirect: redirect_valid with redirect_pc=0x10 while if_pc=0x4 is valid -> next cycle if_valid=0; the cycle after, if_pc=0x10.
- Misaligned redirect: redirect_pc=0x12 -> HALT, err=1, if_valid=0; a later start clears err and refetches pc0.
- Out of range: redirect to 0x100 (index 64) -> HALT, err=1 with no capture.
- Reset and arbitration: rst during RUN with if_valid=1 -> all outputs are reset values the next cycle. Simultaneous stop+redirect -> IDLE with load_ready=1. load_valid during RUN -> imem_we stays 0.
